// File: rtl/sys_write_buffer_if.sv
// Cache-side and system-bus-side signals of the write-through posting buffer.
// The buffer connects through the slave modport; the cache controller / bus
// model on the other side uses the master modport.
interface sys_write_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // cache write port
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              full;
  logic              empty;
  // cache read-miss fill port
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_done;
  // system bus
  logic              sys_strobe;
  logic              sys_rw;
  logic [ADDR_W-1:0] sys_addr;
  logic [DATA_W-1:0] sys_wdata;
  logic [DATA_W-1:0] sys_rdata;

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr, sys_rdata,
    output wr_ack, full, empty, rd_data, rd_done,
           sys_strobe, sys_rw, sys_addr, sys_wdata
  );

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr, sys_rdata,
    input  wr_ack, full, empty, rd_data, rd_done,
           sys_strobe, sys_rw, sys_addr, sys_wdata
  );
endinterface

// File: rtl/sys_write_buffer.sv
// Write-through posting buffer between the cache controller and the system bus.
// Cache writes are queued and drained one per bus transaction; a read-miss fill
// is only issued once the queue is empty, so the fill observes all prior writes.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no bus activity; picks next queued write, else a pending fill
// WR_BUS  | write transaction for the head entry, WAITSTATES cycles long
// RD_BUS  | fill read transaction at rd_addr, WAITSTATES cycles long
// RD_DONE | one cycle with rd_done high, fill data valid in rd_data
module sys_write_buffer #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 4,
  parameter int WAITSTATES = 2
) (
  input  logic             clk,
  input  logic             rst,
  sys_write_buffer_if.slave bus
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = (WAITSTATES > 1) ? $clog2(WAITSTATES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAITSTATES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_BUS  = 2'd1,
    RD_BUS  = 2'd2,
    RD_DONE = 2'd3
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              carry;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;
  logic              full_q;
  logic              empty_q;
  logic              push;
  logic              pop;

  logic              strobe_q;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_done_q;

  // Fills take priority over new writes: the cache is stalled while rd_req is high.
  assign push  = bus.wr_req && !full_q && !bus.rd_req;
  assign carry = (wait_cnt == '0);
  assign pop   = (state == WR_BUS) && carry;

  assign bus.wr_ack     = push;
  assign bus.full       = full_q;
  assign bus.empty      = empty_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_done    = rd_done_q;
  assign bus.sys_strobe = strobe_q;
  assign bus.sys_rw     = rw_q;
  assign bus.sys_addr   = addr_q;
  assign bus.sys_wdata  = wdata_q;

  // Next occupancy; a simultaneous push and pop cancel out.
  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + CNT_W'(1);
    end else if (pop && !push) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  // Queue storage; stale entries are harmless because pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= bus.wr_addr;
      data_mem[tail] <= bus.wr_data;
    end
  end

  // Queue pointers, occupancy and registered full/empty flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push) begin
        tail <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      count   <= count_nxt;
      full_q  <= (count_nxt == CNT_W'(DEPTH));
      empty_q <= (count_nxt == '0);
    end
  end

  // Bus sequencer with registered bus and fill outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      strobe_q  <= 1'b0;
      rw_q      <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      rd_done_q <= 1'b0;
    end else begin
      strobe_q  <= 1'b0;
      rd_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty_q) begin
            state    <= WR_BUS;
            wait_cnt <= WAIT_INIT;
            strobe_q <= 1'b1;
            rw_q     <= 1'b0;
            addr_q   <= addr_mem[head];
            wdata_q  <= data_mem[head];
          end else if (bus.rd_req) begin
            state    <= RD_BUS;
            wait_cnt <= WAIT_INIT;
            strobe_q <= 1'b1;
            rw_q     <= 1'b1;
            addr_q   <= bus.rd_addr;
          end
        end
        WR_BUS: begin
          if (carry) begin
            state <= IDLE;
            rw_q  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end
        RD_BUS: begin
          if (carry) begin
            state     <= RD_DONE;
            rd_data_q <= bus.sys_rdata;
            rd_done_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end
        RD_DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
